// File: rtl/seg14_scroll_driver.sv
// Multiplexed 14-segment display driver with a writable 6-bit character buffer,
// programmable scan rate and optional scrolling of messages longer than the display.
module seg14_scroll_driver #(
    parameter int unsigned NUM_DIGITS = 12,
    parameter int unsigned MSG_DEPTH  = 32,
    parameter int unsigned PRESC_W    = 16,
    parameter bit          SEL_INVERT = 1'b0,
    localparam int unsigned AW = $clog2(MSG_DEPTH),
    localparam int unsigned LW = $clog2(MSG_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [5:0]            wr_char,
    input  logic [LW-1:0]         msg_len,
    input  logic [PRESC_W-1:0]    scan_div,
    input  logic                  scroll_en,
    input  logic [7:0]            scroll_div,
    input  logic                  blank,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [13:0]           segm,
    output logic                  frame_start
);

    localparam int unsigned DW = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(MSG_DEPTH);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_INVERT}};

    logic [PRESC_W-1:0]    presc_q;
    logic [DW-1:0]         dig_q, dig_n;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_n;
    logic [AW-1:0]         offset_q, offset_n, offset_base;
    logic [7:0]            frame_cnt_q, frame_cnt_n;
    logic [LW-1:0]         len_q, len_in, len_eff;
    logic                  scroll_q, scroll_eff;
    logic                  tick, fstart, show_space;
    logic [5:0]            char_rd;
    logic [NUM_DIGITS-1:0] sel_n;
    logic [5:0]            msg_q [MSG_DEPTH];

    // Character code to segment pattern, bit order a b c d e f g1 g2 h i j k l m.
    function automatic logic [13:0] glyph(input logic [5:0] code);
        logic [13:0] g;
        g = 14'b0;
        case (code)
            6'd1:  g = 14'b11101111000000; // A
            6'd2:  g = 14'b11110001010010; // B
            6'd3:  g = 14'b10011100000000; // C
            6'd4:  g = 14'b11110000010010; // D
            6'd5:  g = 14'b10011110000000; // E
            6'd6:  g = 14'b10001110000000; // F
            6'd7:  g = 14'b10111101000000; // G
            6'd8:  g = 14'b01101111000000; // H
            6'd9:  g = 14'b10010000010010; // I
            6'd10: g = 14'b01111000000000; // J
            6'd11: g = 14'b00001110001100; // K
            6'd12: g = 14'b00011100000000; // L
            6'd13: g = 14'b01101100101000; // M
            6'd14: g = 14'b01101100100100; // N
            6'd15: g = 14'b11111100000000; // O
            6'd16: g = 14'b11001111000000; // P
            6'd17: g = 14'b11111100000100; // Q
            6'd18: g = 14'b11001111000100; // R
            6'd19: g = 14'b10110111000000; // S
            6'd20: g = 14'b10000000010010; // T
            6'd21: g = 14'b01111100000000; // U
            6'd22: g = 14'b00001100001001; // V
            6'd23: g = 14'b01101100000101; // W
            6'd24: g = 14'b00000000101101; // X
            6'd25: g = 14'b00000000101010; // Y
            6'd26: g = 14'b10010000001001; // Z
            6'd27: g = 14'b11111100001001; // 0
            6'd28: g = 14'b01100000001000; // 1
            6'd29: g = 14'b11011011000000; // 2
            6'd30: g = 14'b11110001000000; // 3
            6'd31: g = 14'b01100111000000; // 4
            6'd32: g = 14'b10110111000000; // 5
            6'd33: g = 14'b10111111000000; // 6
            6'd34: g = 14'b11100000000000; // 7
            6'd35: g = 14'b11111111000000; // 8
            6'd36: g = 14'b11110111000000; // 9
            default: g = 14'b0;
        endcase
        return g;
    endfunction

    // Scan sequencing, scroll offset and read-pointer next state.
    always_comb begin
        tick        = (presc_q >= scan_div);
        fstart      = tick && (dig_q == LAST_DIG);
        dig_n       = (dig_q == LAST_DIG) ? '0 : dig_q + DW'(1);
        len_in      = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
        len_eff     = fstart ? len_in : len_q;
        scroll_eff  = fstart ? scroll_en : scroll_q;
        offset_base = (LW'(offset_q) >= len_in) ? '0 : offset_q;
        offset_n    = offset_q;
        frame_cnt_n = frame_cnt_q;
        if (fstart) begin
            if (!scroll_en || len_in == '0) begin
                offset_n    = '0;
                frame_cnt_n = '0;
            end else if (scroll_q) begin
                // Count only frames already shown in scroll mode.
                if (frame_cnt_q >= scroll_div) begin
                    frame_cnt_n = '0;
                    offset_n    = (LW'(offset_base) + LW'(1) >= len_in) ? '0 : offset_base + AW'(1);
                end else begin
                    frame_cnt_n = frame_cnt_q + 8'd1;
                    offset_n    = offset_base;
                end
            end else begin
                frame_cnt_n = '0;
                offset_n    = offset_base;
            end
        end
        if (fstart) begin
            rd_ptr_n = offset_n;
        end else begin
            rd_ptr_n = (LW'(rd_ptr_q) + LW'(1) >= len_q) ? '0 : rd_ptr_q + AW'(1);
        end
        show_space = (len_eff == '0) || (!scroll_eff && (LW'(dig_n) >= len_eff));
        char_rd    = msg_q[rd_ptr_n];
        sel_n      = (NUM_DIGITS'(1) << dig_n) ^ SEL_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            dig_q       <= LAST_DIG;
            rd_ptr_q    <= '0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
            len_q       <= '0;
            scroll_q    <= 1'b0;
            sel         <= SEL_OFF;
            segm        <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i < int'(MSG_DEPTH); i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            presc_q     <= tick ? '0 : presc_q + PRESC_W'(1);
            frame_start <= fstart;
            if (tick) begin
                dig_q    <= dig_n;
                rd_ptr_q <= rd_ptr_n;
                if (blank) begin
                    sel  <= SEL_OFF;
                    segm <= '0;
                end else begin
                    sel  <= sel_n;
                    segm <= show_space ? 14'b0 : glyph(char_rd);
                end
            end
            if (fstart) begin
                len_q       <= len_in;
                scroll_q    <= scroll_en;
                offset_q    <= offset_n;
                frame_cnt_q <= frame_cnt_n;
            end
            // Write port is independent of scanning; reads on this edge see the old data.
            if (wr_en && (LW'(wr_addr) < DEPTH_L)) begin
                msg_q[wr_addr] <= wr_char;
            end
        end
    end

endmodule

// File: tb/tb_seg14_scroll_driver.sv
// Directed self-checking bench for seg14_scroll_driver (12 digits, 24-entry buffer).
module tb_seg14_scroll_driver;

    localparam int unsigned ND = 12;
    localparam int unsigned MD = 24;
    localparam int unsigned AW = $clog2(MD);
    localparam int unsigned LW = $clog2(MD + 1);

    localparam logic [13:0] G_SP = 14'b00000000000000;
    localparam logic [13:0] G_A  = 14'b11101111000000;
    localparam logic [13:0] G_J  = 14'b01111000000000;
    localparam logic [13:0] G_L  = 14'b00011100000000;
    localparam logic [13:0] G_N  = 14'b01101100100100;
    localparam logic [13:0] G_P  = 14'b11001111000000;
    localparam logic [13:0] G_T  = 14'b10000000010010;
    localparam logic [13:0] G_U  = 14'b01111100000000;
    localparam logic [13:0] G_X  = 14'b00000000101101;

    logic          clk, rst, wr_en, scroll_en, blank;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_char;
    logic [LW-1:0] msg_len;
    logic [15:0]   scan_div;
    logic [7:0]    scroll_div;
    logic [ND-1:0] sel;
    logic [13:0]   segm;
    logic          frame_start;

    int n_chk = 0;
    int n_fail = 0;
    logic [13:0]   segs [ND];
    logic [ND-1:0] sels [ND];
    int m2 [12] = '{0, 20, 21, 24, 16, 1, 14, 0, 10, 1, 12, 0};
    int b4 [16] = '{1, 10, 12, 14, 16, 20, 21, 24, 0, 1, 10, 12, 14, 16, 20, 21};

    seg14_scroll_driver #(
        .NUM_DIGITS(ND), .MSG_DEPTH(MD), .PRESC_W(16), .SEL_INVERT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .msg_len(msg_len), .scan_div(scan_div), .scroll_en(scroll_en),
        .scroll_div(scroll_div), .blank(blank), .sel(sel), .segm(segm),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] eg(input int c);
        case (c)
            0:  return G_SP;
            1:  return G_A;
            10: return G_J;
            12: return G_L;
            14: return G_N;
            16: return G_P;
            20: return G_T;
            21: return G_U;
            24: return G_X;
            default: return 14'h3fff;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int c);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_char = 6'(c);
        clk1();
        wr_en   = 1'b0;
    endtask

    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin
            clk1();
            n++;
        end while (!frame_start && n < budget);
        chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    // Capture one full frame at scan_div=0: digit k sampled k clocks after frame start.
    task automatic capture();
        wait_fs(200);
        segs[0] = segm;
        sels[0] = sel;
        for (int k = 1; k < int'(ND); k++) begin
            clk1();
            segs[k] = segm;
            sels[k] = sel;
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0; msg_len = '0;
        scan_div = 16'd0; scroll_en = 1'b0; scroll_div = 8'd0; blank = 1'b0;

        // Reset values and first tick
        repeat (3) clk1();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_segm", 32'(segm), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;
        clk1();
        chk("first_sel", 32'(sel), 32'h001);
        chk("first_fs", 32'(frame_start), 32'd1);
        repeat (4) clk1();
        chk("scan_sel4", 32'(sel), 32'h010);
        rst = 1'b1;
        #2;
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_segm", 32'(segm), 32'd0);
        chk("async_fs", 32'(frame_start), 32'd0);
        clk1();
        rst = 1'b0;
        clk1();
        chk("rerst_sel", 32'(sel), 32'h001);

        // Static " TUXPAN JAL "
        msg_len = LW'(12);
        for (int i = 0; i < 12; i++) wr(i, m2[i]);
        capture();
        for (int k = 0; k < int'(ND); k++) begin
            chk($sformatf("static_sel%0d", k), 32'(sels[k]), 32'(1) << k);
            chk($sformatf("static_seg%0d", k), 32'(segs[k]), 32'(eg(m2[k])));
        end
        clk1();
        chk("fs_period", 32'(frame_start), 32'd1);

        // Short message "TUX", static then scrolling
        wr(0, 20); wr(1, 21); wr(2, 24);
        msg_len = LW'(3);
        capture();
        chk("short_d0", 32'(segs[0]), 32'(G_T));
        chk("short_d2", 32'(segs[2]), 32'(G_X));
        chk("short_d3", 32'(segs[3]), 32'(G_SP));
        chk("short_d11", 32'(segs[11]), 32'(G_SP));
        scroll_en = 1'b1;
        scroll_div = 8'd255;
        capture();
        chk("wrap_d3", 32'(segs[3]), 32'(G_T));
        chk("wrap_d4", 32'(segs[4]), 32'(G_U));
        chk("wrap_d11", 32'(segs[11]), 32'(G_X));

        // Scroll 16 chars, two frames per step
        scroll_en = 1'b0;
        msg_len = LW'(16);
        for (int i = 0; i < 16; i++) wr(i, b4[i]);
        wait_fs(200);
        scroll_en = 1'b1;
        scroll_div = 8'd1;
        for (int k = 1; k <= 34; k++) begin
            wait_fs(40);
            chk($sformatf("scroll_f%0d", k), 32'(segm), 32'(eg(b4[((k - 1) / 2) % 16])));
        end

        // Prescaler and blank
        scroll_en = 1'b0;
        msg_len = LW'(12);
        wait_fs(200);
        scan_div = 16'd3;
        wait_fs(200);
        chk("presc_t0", 32'(sel), 32'h001);
        clk1();
        chk("presc_fs_pulse", 32'(frame_start), 32'd0);
        repeat (2) clk1();
        chk("presc_t3", 32'(sel), 32'h001);
        clk1();
        chk("presc_t4", 32'(sel), 32'h002);
        repeat (4) clk1();
        chk("presc_t8", 32'(sel), 32'h004);
        blank = 1'b1;
        repeat (4) clk1();
        chk("blank_sel", 32'(sel), 32'd0);
        chk("blank_segm", 32'(segm), 32'd0);
        repeat (4) clk1();
        chk("blank_sel2", 32'(sel), 32'd0);
        blank = 1'b0;
        repeat (4) clk1();
        chk("unblank_sel", 32'(sel), 32'h020);
        chk("unblank_segm", 32'(segm), 32'(G_T));
        scan_div = 16'd0;

        // Out-of-range write, same-edge write, mid-frame length change
        wr(24, 24);
        capture();
        chk("oor_d0", 32'(segs[0]), 32'(G_A));
        chk("oor_d3", 32'(segs[3]), 32'(G_N));
        wait_fs(200);
        repeat (2) clk1();
        wr_en = 1'b1; wr_addr = AW'(3); wr_char = 6'd24;
        clk1();
        wr_en = 1'b0;
        chk("same_edge_old", 32'(segm), 32'(G_N));
        capture();
        chk("same_edge_new", 32'(segs[3]), 32'(G_X));
        wait_fs(200);
        repeat (2) clk1();
        msg_len = LW'(2);
        repeat (3) clk1();
        chk("len_mid_frame", 32'(segm), 32'(G_T));
        capture();
        chk("len_next_d1", 32'(segs[1]), 32'(G_J));
        chk("len_next_d2", 32'(segs[2]), 32'(G_SP));
        chk("len_next_d5", 32'(segs[5]), 32'(G_SP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
